// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
//
// Takes one parallel payload word over a valid/ready handshake and shifts the
// frame out MSB-first, one bit per symbol tick, towards the convolutional
// encoder / BPSK mapper. Frame layout on the wire:
//   SYNC_WORD (SYNC_WIDTH bits) | payload (DATA_WIDTH bits) | TAIL_LEN zeros
// The trailing zeros flush the encoder memory.
//
// Ports
//   clk_sig        in   system clock, rising edge
//   reset_sig      in   asynchronous reset, active high
//   data_in_sig    in   payload word
//   data_valid_sig in   payload word present
//   data_ready_sig out  block can accept a word (only in IDLE)
//   tick_sig       in   symbol strobe, single-cycle carry of the rate counter
//   bit_sig        out  current serial bit, held between ticks
//   bit_valid_sig  out  one-cycle pulse marking a new bit on bit_sig
//   busy_sig       out  frame in progress
//   frame_done_sig out  one-cycle pulse together with the last bit
//
// All outputs are registered. A bit appears one cycle after its tick.
// -----------------------------------------------------------------------------
module frame_serializer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hB8,
    parameter int                    TAIL_LEN   = 2
) (
    input  logic                  clk_sig,
    input  logic                  reset_sig,
    input  logic [DATA_WIDTH-1:0] data_in_sig,
    input  logic                  data_valid_sig,
    output logic                  data_ready_sig,
    input  logic                  tick_sig,
    output logic                  bit_sig,
    output logic                  bit_valid_sig,
    output logic                  busy_sig,
    output logic                  frame_done_sig
);

    localparam int MAX_SD  = (SYNC_WIDTH > DATA_WIDTH) ? SYNC_WIDTH : DATA_WIDTH;
    localparam int MAX_SDT = (MAX_SD > TAIL_LEN) ? MAX_SD : TAIL_LEN;
    localparam int MAX_LEN = (MAX_SDT > 2) ? MAX_SDT : 2;
    localparam int IDX_W   = $clog2(MAX_LEN);

    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] TAIL_LAST = IDX_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
    localparam logic             HAS_TAIL  = (TAIL_LEN > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SYNC_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  bit_q;
    logic                  bit_valid_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  ready_q;

    // Next serial bit and section bookkeeping for the current state.
    logic cur_bit_d;
    logic sec_last_d;
    logic frame_end_d;

    always_comb begin
        cur_bit_d   = 1'b0;
        sec_last_d  = 1'b0;
        frame_end_d = 1'b0;
        case (state_q)
            SYNC: begin
                cur_bit_d  = sync_q[SYNC_WIDTH-1];
                sec_last_d = (idx_q == SYNC_LAST);
            end
            DATA: begin
                cur_bit_d   = data_q[DATA_WIDTH-1];
                sec_last_d  = (idx_q == DATA_LAST);
                // Without a tail the last payload bit closes the frame.
                frame_end_d = sec_last_d && !HAS_TAIL;
            end
            TAIL: begin
                cur_bit_d   = 1'b0;
                sec_last_d  = (idx_q == TAIL_LAST);
                frame_end_d = sec_last_d;
            end
            default: begin
                cur_bit_d   = 1'b0;
                sec_last_d  = 1'b0;
                frame_end_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            sync_q       <= '0;
            data_q       <= '0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    // Ticks here are ignored, including one coincident with
                    // acceptance: the first bit waits for the next tick.
                    if (data_valid_sig && ready_q) begin
                        data_q  <= data_in_sig;
                        sync_q  <= SYNC_WORD;
                        idx_q   <= '0;
                        state_q <= SYNC;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (tick_sig) begin
                        bit_q       <= cur_bit_d;
                        bit_valid_q <= 1'b1;
                        idx_q       <= idx_q + IDX_W'(1);
                        if (state_q == SYNC) sync_q <= sync_q << 1;
                        if (state_q == DATA) data_q <= data_q << 1;
                        if (sec_last_d) begin
                            idx_q <= '0;
                            if (frame_end_d) begin
                                // Back to IDLE with the final bit so a new
                                // word can be accepted in the done cycle.
                                state_q      <= IDLE;
                                busy_q       <= 1'b0;
                                ready_q      <= 1'b1;
                                frame_done_q <= 1'b1;
                            end else if (state_q == SYNC) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= TAIL;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign data_ready_sig = ready_q;
    assign bit_sig        = bit_q;
    assign bit_valid_sig  = bit_valid_q;
    assign busy_sig       = busy_q;
    assign frame_done_sig = frame_done_q;

endmodule

// File: tb/tb_frame_serializer.sv
module tb_frame_serializer;

    logic clk_sig = 1'b0;
    always #5 clk_sig = ~clk_sig;

    logic        reset_sig;
    logic        tick_sig;

    logic [15:0] din_a;
    logic        dv_a;
    logic        ready_a, bit_a, bv_a, busy_a, done_a;

    logic [7:0]  din_b;
    logic        dv_b;
    logic        ready_b, bit_b, bv_b, busy_b, done_b;

    frame_serializer dut_a (
        .clk_sig        (clk_sig),
        .reset_sig      (reset_sig),
        .data_in_sig    (din_a),
        .data_valid_sig (dv_a),
        .data_ready_sig (ready_a),
        .tick_sig       (tick_sig),
        .bit_sig        (bit_a),
        .bit_valid_sig  (bv_a),
        .busy_sig       (busy_a),
        .frame_done_sig (done_a)
    );

    frame_serializer #(.DATA_WIDTH(8), .TAIL_LEN(0)) dut_b (
        .clk_sig        (clk_sig),
        .reset_sig      (reset_sig),
        .data_in_sig    (din_b),
        .data_valid_sig (dv_b),
        .data_ready_sig (ready_b),
        .tick_sig       (tick_sig),
        .bit_sig        (bit_b),
        .bit_valid_sig  (bv_b),
        .busy_sig       (busy_b),
        .frame_done_sig (done_b)
    );

    typedef struct {
        logic b;
        bit   first;
        bit   last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int   tests = 0;
    int   fails = 0;
    int   popped_a = 0;
    int   popped_b = 0;
    bit   cont_mode = 1'b0;
    logic prev_bv_a = 1'b0;
    logic last_tick = 1'b0;

    localparam logic [7:0] SYNC = 8'hB8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [15:0] d);
        for (int i = 7; i >= 0; i--) qa.push_back('{b: SYNC[i], first: (i == 7), last: 1'b0});
        for (int i = 15; i >= 0; i--) qa.push_back('{b: d[i], first: 1'b0, last: 1'b0});
        for (int i = 0; i < 2; i++) qa.push_back('{b: 1'b0, first: 1'b0, last: 1'b0});
        qa[qa.size()-1].last = 1'b1;
    endtask

    task automatic push_b(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) qb.push_back('{b: SYNC[i], first: (i == 7), last: 1'b0});
        for (int i = 7; i >= 0; i--) qb.push_back('{b: d[i], first: 1'b0, last: 1'b0});
        qb[qb.size()-1].last = 1'b1;
    endtask

    // Holds tick for one clock; returns 1 time unit after the edge.
    task automatic drive(input logic t);
        tick_sig = t;
        @(posedge clk_sig);
        #1;
    endtask

    task automatic wait_empty_a(input int period, input string tag);
        int n = 0;
        while (qa.size() != 0 && n < 2000) begin
            drive((n % period) == period - 1);
            n++;
        end
        tick_sig = 1'b0;
        check(tag, qa.size(), 0);
    endtask

    task automatic wait_empty_b(input int period, input string tag);
        int n = 0;
        while (qb.size() != 0 && n < 2000) begin
            drive((n % period) == period - 1);
            n++;
        end
        tick_sig = 1'b0;
        check(tag, qb.size(), 0);
    endtask

    always @(posedge clk_sig) last_tick <= tick_sig;

    // Scoreboard for the default instance.
    always @(negedge clk_sig) begin
        if (!reset_sig) begin
            if (bv_a) begin
                check("a_unexpected_bit", (qa.size() != 0), 1);
                if (qa.size() != 0) begin
                    exp_t e;
                    e = qa.pop_front();
                    popped_a++;
                    check("a_bit", bit_a, e.b);
                    check("a_done", done_a, e.last);
                    check("a_tick_latency", last_tick, 1);
                    if (e.last) begin
                        check("a_busy_at_done", busy_a, 0);
                        check("a_ready_at_done", ready_a, 1);
                    end else begin
                        check("a_busy_in_frame", busy_a, 1);
                    end
                    if (cont_mode && !e.first) check("a_consecutive", prev_bv_a, 1);
                end
            end else begin
                check("a_done_without_bit", done_a, 0);
            end
            prev_bv_a = bv_a;
        end
    end

    // Scoreboard for the TAIL_LEN=0, DATA_WIDTH=8 instance.
    always @(negedge clk_sig) begin
        if (!reset_sig) begin
            if (bv_b) begin
                check("b_unexpected_bit", (qb.size() != 0), 1);
                if (qb.size() != 0) begin
                    exp_t e;
                    e = qb.pop_front();
                    popped_b++;
                    check("b_bit", bit_b, e.b);
                    check("b_done", done_b, e.last);
                    if (e.last) check("b_ready_at_done", ready_b, 1);
                end
            end else begin
                check("b_done_without_bit", done_b, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepted;

        reset_sig = 1'b1;
        tick_sig  = 1'b0;
        dv_a = 1'b0; din_a = '0;
        dv_b = 1'b0; din_b = '0;

        // Reset state.
        #22;
        check("rst_ready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_bv", bv_a, 0);
        check("rst_bit", bit_a, 0);
        check("rst_done", done_a, 0);
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b0;
        check("ready_before_edge", ready_a, 0);
        drive(1'b0);
        check("ready_after_release", ready_a, 1);
        check("busy_idle", busy_a, 0);

        // Ticks with no data emit nothing.
        repeat (4) drive(1'b1);
        tick_sig = 1'b0;
        check("idle_ticks_no_bits", popped_a, 0);

        // Basic frame; the acceptance cycle carries a tick that must be ignored.
        popped_a = 0;
        push_a(16'hC35A);
        din_a = 16'hC35A;
        dv_a  = 1'b1;
        drive(1'b1);
        dv_a  = 1'b0;
        check("busy_after_accept", busy_a, 1);
        check("ready_after_accept", ready_a, 0);

        // Valid with a different word while busy must be refused.
        din_a = 16'hFFFF;
        dv_a  = 1'b1;
        for (int i = 0; i < 8; i++) drive((i % 4) == 3);
        check("ready_while_busy", ready_a, 0);
        dv_a = 1'b0;
        wait_empty_a(4, "basic_frame_complete");
        check("basic_pulse_count", popped_a, 26);
        drive(1'b0);
        check("idle_after_frame_busy", busy_a, 0);
        check("idle_after_frame_ready", ready_a, 1);

        // Reset mid-frame after 10 bits.
        popped_a = 0;
        push_a(16'h5A5A);
        din_a = 16'h5A5A;
        dv_a  = 1'b1;
        drive(1'b0);
        dv_a  = 1'b0;
        n = 0;
        while (popped_a < 10 && n < 500) begin
            drive((n % 2) == 1);
            n++;
        end
        tick_sig = 1'b0;
        check("bits_before_abort", popped_a, 10);
        #3;
        reset_sig = 1'b1;
        #1;
        check("abort_bv", bv_a, 0);
        check("abort_done", done_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_ready", ready_a, 0);
        check("abort_bit", bit_a, 0);
        qa.delete();
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b0;
        drive(1'b0);
        check("ready_after_abort", ready_a, 1);

        popped_a = 0;
        push_a(16'h0001);
        din_a = 16'h0001;
        dv_a  = 1'b1;
        drive(1'b0);
        dv_a  = 1'b0;
        wait_empty_a(3, "post_abort_frame_complete");
        check("post_abort_pulse_count", popped_a, 26);
        drive(1'b0);

        // Back-to-back frames with a tick every cycle and valid held high.
        popped_a  = 0;
        cont_mode = 1'b1;
        push_a(16'h1234);
        push_a(16'hABCD);
        din_a    = 16'h1234;
        dv_a     = 1'b1;
        accepted = 0;
        n        = 0;
        while (qa.size() != 0 && n < 300) begin
            if (dv_a && ready_a) begin
                accepted++;
                if (accepted == 2) check("second_accept_in_done_cycle", done_a, 1);
            end
            drive(1'b1);
            if (accepted == 1) din_a = 16'hABCD;
            if (accepted == 2) dv_a = 1'b0;
            n++;
        end
        tick_sig  = 1'b0;
        dv_a      = 1'b0;
        check("b2b_queue_empty", qa.size(), 0);
        check("b2b_accept_count", accepted, 2);
        check("b2b_pulse_count", popped_a, 52);
        drive(1'b0);
        cont_mode = 1'b0;

        // Variant: no tail, 8-bit payload.
        popped_b = 0;
        push_b(8'h81);
        din_b = 8'h81;
        dv_b  = 1'b1;
        drive(1'b0);
        dv_b  = 1'b0;
        check("b_busy_after_accept", busy_b, 1);
        wait_empty_b(3, "b_frame_complete");
        check("b_pulse_count", popped_b, 16);
        drive(1'b0);
        check("b_ready_after_frame", ready_b, 1);

        repeat (3) drive(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
